ila_capture_ctrl: RTL and testbench

Parametrised successor to the single-port ILA sample store. It combines a circular sample RAM, a configurable input synchronisation pipeline and a capture state machine. The state machine supports arm, a programmable pre-trigger window, trigger detection, post-trigger fill and a done flag. Readout is relative to the oldest captured sample, so the host-side UART/JTAG reader needs no address arithmetic.

---
 rtl/ila_pkg.sv | 23 ++
 rtl/ila_sample_ram.sv | 44 ++++
 rtl/ila_capture_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ila_capture_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ila_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ila_pkg
// Brief   : Shared capture-state encoding and pre-trigger clamp helper.
// Revision: 1.0 - initial release
// ============================================================================
package ila_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } ila_state_t;

    function automatic logic [31:0] clamp_pretrig(input logic [31:0] i_pre,
                                                  input logic [31:0] i_max);
        return (i_pre > i_max) ? i_max : i_pre;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ila_sample_ram.sv
`default_nettype none
// ============================================================================
// Module  : ila_sample_ram
// Brief   : Simple dual-address sample RAM, one write port, registered read.
// Revision: 1.0 - initial release
// ============================================================================
module ila_sample_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Array carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ila_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ila_capture_ctrl
// Brief   : ILA capture controller: sync pipeline, pre/post-trigger FSM,
//           circular sample store with oldest-first readout.
// Revision: 1.0 - initial release
// ============================================================================
module ila_capture_ctrl
    import ila_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int ADDR_WIDTH             = 9,
    parameter int SIGNAL_SYNCHRONISATION = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  trig_in,
    input  logic                  arm,
    input  logic [ADDR_WIDTH-1:0] pretrig,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] trig_index
);

    localparam int c_STAGES = SIGNAL_SYNCHRONISATION + 1;
    localparam logic [ADDR_WIDTH-1:0] c_MAX_IDX = ADDR_WIDTH'(2 ** ADDR_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_di_pipe [c_STAGES];
    logic [c_STAGES-1:0]   r_trig_pipe;

    ila_state_t            r_state;
    ila_state_t            w_next_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_pre_q;
    logic [ADDR_WIDTH-1:0] r_trig_ptr;
    logic                  r_triggered;

    logic                  w_we;
    logic                  w_start;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_pre_clamped;
    logic [ADDR_WIDTH-1:0] w_rd_phys;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_STAGES; i++) begin
                r_di_pipe[i]   <= '0;
                r_trig_pipe[i] <= 1'b0;
            end
        end else begin
            r_di_pipe[0]   <= di;
            r_trig_pipe[0] <= trig_in;
            for (int i = 1; i < c_STAGES; i++) begin
                r_di_pipe[i]   <= r_di_pipe[i-1];
                r_trig_pipe[i] <= r_trig_pipe[i-1];
            end
        end
    end

    assign w_pre_clamped = ADDR_WIDTH'(clamp_pretrig(32'(pretrig), 32'(c_MAX_IDX)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    w_start      = 1'b1;
                    w_next_state = S_PRE;
                end
            end
            S_PRE: begin
                if (r_pre_q == '0) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_we = 1'b1;
                    if (r_cnt + ADDR_WIDTH'(1) == r_pre_q) begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_we = 1'b1;
                if (r_trig_pipe[c_STAGES-1]) begin
                    w_accept     = 1'b1;
                    // A full pre-trigger window leaves only the trigger sample to write.
                    w_next_state = (r_pre_q == c_MAX_IDX) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                w_we = 1'b1;
                if (r_cnt == c_MAX_IDX - r_pre_q) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_pre_q     <= '0;
            r_trig_ptr  <= '0;
            r_triggered <= 1'b0;
        end else if (w_start) begin
            r_pre_q     <= w_pre_clamped;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_triggered <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            // r_cnt counts pre-trigger writes in PRE, trigger-inclusive writes in POST.
            if (w_accept) begin
                r_trig_ptr  <= r_wr_ptr;
                r_triggered <= 1'b1;
                r_cnt       <= ADDR_WIDTH'(1);
            end else if (w_we && r_state != S_WAIT) begin
                r_cnt <= r_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    assign w_rd_phys = r_trig_ptr - r_pre_q + rd_addr;

    ila_sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_di_pipe[c_STAGES-1]),
        .i_re    (r_state == S_DONE),
        .i_raddr (w_rd_phys),
        .o_rdata (rd_data)
    );

    assign busy       = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign done       = (r_state == S_DONE);
    assign triggered  = r_triggered;
    assign trig_index = r_pre_q;

endmodule
`default_nettype wire

// File: tb/tb_ila_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ila_capture_ctrl
// Brief   : Randomised self-checking bench; two DUTs (sync 0 and 2) against an
//           edge-indexed capture model built from the input history.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ila_capture_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int HMAX  = 16384;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] di;
    logic          trig_in;
    logic          arm;
    logic [AW-1:0] pretrig;
    logic [AW-1:0] rd_addr;

    logic          busy_o      [2];
    logic          triggered_o [2];
    logic          done_o      [2];
    logic [DW-1:0] rd_data_o   [2];
    logic [AW-1:0] tidx_o      [2];

    always #5 clk = ~clk;

    ila_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIGNAL_SYNCHRONISATION(0)) u_dut_s0 (
        .clk(clk), .rst(rst), .di(di), .trig_in(trig_in), .arm(arm), .pretrig(pretrig),
        .busy(busy_o[0]), .triggered(triggered_o[0]), .done(done_o[0]),
        .rd_addr(rd_addr), .rd_data(rd_data_o[0]), .trig_index(tidx_o[0])
    );

    ila_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIGNAL_SYNCHRONISATION(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .di(di), .trig_in(trig_in), .arm(arm), .pretrig(pretrig),
        .busy(busy_o[1]), .triggered(triggered_o[1]), .done(done_o[1]),
        .rd_addr(rd_addr), .rd_data(rd_data_o[1]), .trig_index(tidx_o[1])
    );

    // Input history indexed by clock edge number; the model derives everything from it.
    int            n = 0;
    logic [DW-1:0] h_di [HMAX];
    bit            h_tr [HMAX];

    bit            m_active [2];
    int            m_arm    [2];
    int            m_P      [2];
    int            m_trig   [2];
    int            m_done   [2];
    int            m_tidx   [2];
    logic [DW-1:0] m_rd     [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", tag, act, exp, n);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit tr_at(input int idx);
        return (idx > 0) ? h_tr[idx] : 1'b0;
    endfunction

    function automatic bit m_is_done(input int d);
        return m_active[d] && (m_done[d] >= 0) && (n >= m_done[d]);
    endfunction

    function automatic void model_reset(input int d);
        m_active[d] = 1'b0;
        m_trig[d]   = -1;
        m_done[d]   = -1;
        m_tidx[d]   = 0;
        m_P[d]      = 0;
        m_arm[d]    = 0;
        m_rd[d]     = '0;
    endfunction

    function automatic void model_edge(input int d);
        int  L;
        int  ws;
        bit  was_done;
        L = lat(d);
        if (rst) begin
            model_reset(d);
        end else begin
            was_done = m_active[d] && (m_done[d] >= 0) && (m_done[d] < n);
            if (was_done) begin
                m_rd[d] = h_di[m_trig[d] - L - m_P[d] + int'(rd_addr)];
            end
            if (arm && (!m_active[d] || was_done)) begin
                m_active[d] = 1'b1;
                m_arm[d]    = n;
                m_P[d]      = int'(pretrig);
                m_tidx[d]   = int'(pretrig);
                m_trig[d]   = -1;
                m_done[d]   = -1;
            end else if (m_active[d] && m_trig[d] < 0) begin
                ws = (m_P[d] == 0) ? m_arm[d] + 2 : m_arm[d] + 1 + m_P[d];
                if (n >= ws && tr_at(n - L)) begin
                    m_trig[d] = n;
                    m_done[d] = n + DEPTH - 1 - m_P[d];
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        n++;
        h_di[n] = rst ? '0 : di;
        h_tr[n] = rst ? 1'b0 : trig_in;
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("s%0d busy", d), 32'(busy_o[d]), 32'(m_active[d] && !m_is_done(d)));
            chk($sformatf("s%0d triggered", d), 32'(triggered_o[d]), 32'(m_trig[d] >= 0));
            chk($sformatf("s%0d done", d), 32'(done_o[d]), 32'(m_is_done(d)));
            chk($sformatf("s%0d trig_index", d), 32'(tidx_o[d]), 32'(m_tidx[d]));
            chk($sformatf("s%0d rd_data", d), 32'(rd_data_o[d]), 32'(m_rd[d]));
        end
    endtask

    function automatic void drive(input int mode, input int cnt, input int trig_at, input int k);
        case (mode)
            0: begin
                di      = DW'(cnt);
                trig_in = (cnt == trig_at);
            end
            1: begin
                di      = DW'($urandom);
                trig_in = 1'b1;
            end
            default: begin
                di      = DW'($urandom);
                trig_in = ($urandom_range(0, 5) == 0) || (k > 200);
            end
        endcase
    endfunction

    // mode 0: counter data, trigger on value trig_at; 1: trigger held high; 2: random.
    task automatic run_capture(input int pre, input int mode, input int trig_at,
                               input bit mid_arm, input bit do_rst, input int base);
        int eff;
        bit fin;
        bit aborted;
        fin     = 1'b0;
        aborted = 1'b0;
        eff     = (pre > DEPTH - 1) ? DEPTH - 1 : pre;
        pretrig = AW'(eff);
        arm     = 1'b1;
        drive(mode, 0, trig_at, 0);
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 600 && !fin; k++) begin
            drive(mode, k, trig_at, k);
            arm = mid_arm && (k == 10);
            if (mid_arm && k == 10) pretrig = AW'(eff + 5);
            if (do_rst && k == trig_at + 6) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                tick();
                aborted = 1'b1;
                fin     = 1'b1;
            end else begin
                tick();
                fin = m_is_done(0) && m_is_done(1);
            end
        end
        arm     = 1'b0;
        trig_in = 1'b0;
        if (!fin) chk("capture timeout", 32'(0), 32'(1));
        if (!aborted) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_addr = AW'(i);
                di      = DW'($urandom);
                tick();
                if (base >= 0) begin
                    for (int d = 0; d < 2; d++)
                        chk($sformatf("s%0d ordered rd%0d", d, i), 32'(rd_data_o[d]), 32'(base + i));
                end
            end
            for (int d = 0; d < 2; d++)
                chk($sformatf("s%0d final trig_index", d), 32'(tidx_o[d]), 32'(eff));
        end
        for (int i = 0; i < 3; i++) begin
            di = DW'($urandom);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) model_reset(d);
        rst     = 1'b1;
        di      = '0;
        trig_in = 1'b0;
        arm     = 1'b0;
        pretrig = '0;
        rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        run_capture(4,  0, 40,  1'b0, 1'b0, 36);   // pre-trigger retention
        run_capture(8,  1, 0,   1'b0, 1'b0, -1);   // early trigger suppressed
        run_capture(0,  0, 20,  1'b0, 1'b0, 20);   // pretrig = 0
        run_capture(0,  2, 0,   1'b0, 1'b0, -1);
        run_capture(31, 2, 0,   1'b0, 1'b0, -1);   // clamp to DEPTH-1
        run_capture(4,  0, 50,  1'b1, 1'b0, 46);   // wrap in WAIT, arm ignored
        run_capture(6,  0, 100, 1'b0, 1'b0, 94);   // sync alignment
        run_capture(4,  0, 40,  1'b0, 1'b1, -1);   // reset during POST
        run_capture(5,  0, 30,  1'b1, 1'b0, 25);   // capture after reset
        for (int r = 0; r < 6; r++) begin
            run_capture(int'($urandom_range(0, 20)), 2, 0, 1'(r % 2), 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
